// File: rtl/act_pkg.sv
// Activation function encodings shared by requesters and the scheduler.
// Ports: none (package).
package act_pkg;

    localparam logic [1:0] ACT_BYPASS  = 2'd0;
    localparam logic [1:0] ACT_LRELU   = 2'd1;
    localparam logic [1:0] ACT_SIGMOID = 2'd2;
    localparam logic [1:0] ACT_TANH    = 2'd3;

endpackage

// File: rtl/act_rr_scheduler_if.sv
// Request/result handshake bundle of the activation scheduler.
// master: requesters + downstream sink; slave: the scheduler.
interface act_rr_scheduler_if #(
    parameter int W       = 16,
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_data;
    logic [NUM_REQ*2-1:0] req_func;
    logic signed [W-1:0]  cfg_slope;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  out_data;
    logic [IDW-1:0]       out_id;
    logic [1:0]           out_func;

    modport master (
        output req_valid, req_data, req_func,
        output cfg_slope, out_ready,
        input  req_ready, out_valid,
        input  out_data, out_id, out_func
    );

    modport slave (
        input  req_valid, req_data, req_func,
        input  cfg_slope, out_ready,
        output req_ready, out_valid,
        output out_data, out_id, out_func
    );

endinterface

// File: rtl/act_rr_scheduler_act_unit.sv
// Combinational activation: bypass / LReLU / 3-segment sigmoid / hard tanh.
// Ports: x, slope, func in; y out (all signed W except func).
module act_unit
    import act_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] slope,
    input  logic [1:0]          func,
    output logic signed [W-1:0] y
);

    localparam logic signed [W-1:0] ONE  = W'(1);
    localparam logic signed [W-1:0] MONE = -W'(1);

    // Only the low W bits of the product are kept.
    logic signed [W-1:0] prod;
    logic signed [W-1:0] half;

    assign prod = x * slope;
    assign half = (x >>> 1) + ONE;

    always_comb begin
        y = x;
        unique case (func)
            ACT_BYPASS:  y = x;
            ACT_LRELU:   y = (x > 0) ? x : prod;
            ACT_SIGMOID: begin
                if (x > 2)       y = ONE;
                else if (x < -2) y = '0;
                else             y = half >>> 1;
            end
            ACT_TANH: begin
                if (x >= 1)       y = ONE;
                else if (x <= -1) y = MONE;
                else              y = x;
            end
        endcase
    end

endmodule

// File: rtl/act_rr_scheduler.sv
// Round-robin shared activation datapath, 2-stage valid/ready pipeline.
// Ports: clk, rst_n, bus (slave); perf_* only with ACT_RR_PERF_EN.
module act_rr_scheduler
    import act_pkg::*;
#(
    parameter int W       = 16,
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ACT_RR_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_accept_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    act_rr_scheduler_if.slave bus
);

    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      gnt;
    logic [IDW-1:0]      nxt_ptr;
    logic                found;
    logic                accept;
    logic                s1_valid;
    logic                s1_free;
    logic                s2_free;
    logic signed [W-1:0] s1_data;
    logic signed [W-1:0] s1_slope;
    logic [1:0]          s1_func;
    logic [IDW-1:0]      s1_id;
    logic signed [W-1:0] y;

    // Scan starting at ptr, wrapping; first valid wins.
    always_comb begin : arb
        logic [IDW:0] sum;
        found = 1'b0;
        gnt   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ))
                sum = sum - (IDW+1)'(NUM_REQ);
            if (!found && bus.req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = sum[IDW-1:0];
            end
        end
    end

    assign s2_free = !bus.out_valid || bus.out_ready;
    assign s1_free = !s1_valid || s2_free;
    // Gating with rst_n keeps ready low while reset is held.
    assign accept  = found && s1_free && rst_n;
    assign nxt_ptr = (gnt == IDW'(NUM_REQ-1)) ? '0 : gnt + 1'b1;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= '0;
        else if (accept) ptr <= nxt_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_slope <= '0;
            s1_func  <= '0;
            s1_id    <= '0;
        end else if (s1_free) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= bus.req_data[int'(gnt)*W +: W];
                s1_func  <= bus.req_func[int'(gnt)*2 +: 2];
                s1_slope <= bus.cfg_slope;
                s1_id    <= gnt;
            end
        end
    end

    act_unit #(.W(W)) u_act (
        .x     (s1_data),
        .slope (s1_slope),
        .func  (s1_func),
        .y     (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
            bus.out_func  <= '0;
        end else if (s2_free) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data <= y;
                bus.out_id   <= s1_id;
                bus.out_func <= s1_func;
            end
        end
    end

`ifdef ACT_RR_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_accept_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else if (perf_clr) begin
            perf_accept_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (accept && !(&perf_accept_cnt))
                perf_accept_cnt <= perf_accept_cnt + 32'd1;
            if (bus.out_valid && !bus.out_ready && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_act_rr_scheduler.sv
// Randomized bench for act_rr_scheduler against a queue-based reference.
// Optional perf counters are checked when ACT_RR_PERF_EN is defined.
module tb_act_rr_scheduler;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    act_rr_scheduler_if #(.W(W), .NUM_REQ(N), .IDW(IDW)) bus();

`ifdef ACT_RR_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_accept_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    act_rr_scheduler #(.W(W), .NUM_REQ(N), .IDW(IDW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef ACT_RR_PERF_EN
        .perf_clr        (perf_clr),
        .perf_accept_cnt (perf_accept_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
`endif
        .bus             (bus)
    );

    typedef struct {
        int id;
        int func;
        int y;
        int vis;
    } item_t;

    item_t q[$];
    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int ptr_m = 0;
    int dut_acc = 0;
    int req_pct = 100;
    int rdy_pct = 100;
    int acc_m = 0;
    int stall_m = 0;
    logic [3:0] mask = 4'hf;
    bit pend[N];
    logic signed [W-1:0] pdata[N];
    logic [1:0] pfunc[N];
    logic signed [W-1:0] slope_drv = '0;
    bit slope_rand = 1'b1;
    bit clr_en = 1'b0;
    int dir_x[$];
    int dir_f[$];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] want);
        ncmp++;
        if (obs !== want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                     tag, obs, want, cyc);
        end
    endtask

    function automatic int act_ref(int x, int f, int s);
        logic signed [W-1:0] t;
        case (f)
            1: begin
                if (x > 0) return x;
                t = W'(x * s);
                return int'(t);
            end
            2: begin
                if (x > 2) return 1;
                if (x < -2) return 0;
                return ((x >>> 1) + 1) >>> 1;
            end
            3: return (x >= 1) ? 1 : (x <= -1) ? -1 : x;
            default: return x;
        endcase
    endfunction

    function automatic bit pend_any();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_req(input int i);
        int v;
        if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 8)) - 4;
        else v = int'($urandom_range(0, 65535)) - 32768;
        pend[i] = 1'b1;
        pdata[i] = W'(v);
        pfunc[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_data[i*W +: W] = pdata[i];
            bus.req_func[i*2 +: 2] = pfunc[i];
        end
    endtask

    task automatic cycle();
        int g;
        int r;
        bit can;
        bit ov;
        logic [3:0] rdy;
        item_t it;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                if (i == 0 && dir_x.size() > 0) begin
                    pend[0] = 1'b1;
                    pdata[0] = W'(dir_x.pop_front());
                    pfunc[0] = 2'(dir_f.pop_front());
                end else if (mask[i] && $urandom_range(0, 99) < req_pct) begin
                    new_req(i);
                end
            end
        end
        if (slope_rand) slope_drv = W'($urandom);
        bus.cfg_slope = slope_drv;
        bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
`ifdef ACT_RR_PERF_EN
        perf_clr = clr_en && ($urandom_range(0, 39) == 0);
`endif
        drive();
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            r = (ptr_m + k) % N;
            if (g < 0 && pend[r]) g = r;
        end
        can = (q.size() < 2) || bus.out_ready;
        rdy = (g >= 0 && can) ? 4'(1 << g) : 4'h0;
        chk("req_ready", bus.req_ready, rdy);
        ov = (q.size() > 0) && (cyc >= q[0].vis);
        chk("out_valid", bus.out_valid, ov);
        if (ov) begin
            chk("out_id", bus.out_id, q[0].id);
            chk("out_func", bus.out_func, q[0].func);
            chk("out_data", bus.out_data, q[0].y);
        end
`ifdef ACT_RR_PERF_EN
        chk("perf_accept", perf_accept_cnt, acc_m);
        chk("perf_stall", perf_stall_cnt, stall_m);
        if (perf_clr) begin
            acc_m = 0;
            stall_m = 0;
        end else begin
            if (rdy != 0) acc_m++;
            if (ov && !bus.out_ready) stall_m++;
        end
`endif
        if ((bus.req_valid & bus.req_ready) != 0) dut_acc++;
        if (ov && bus.out_ready) begin
            void'(q.pop_front());
            if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
        end
        if (rdy != 0) begin
            it.id = g;
            it.func = int'(pfunc[g]);
            it.y = act_ref(int'(pdata[g]), int'(pfunc[g]), int'(slope_drv));
            it.vis = cyc + 2;
            q.push_back(it);
            pend[g] = 1'b0;
            ptr_m = (g + 1) % N;
        end
        cyc++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        mask = 4'h0;
        rdy_pct = 100;
        while ((pend_any() || q.size() > 0 || dir_x.size() > 0) && k < 60) begin
            cycle();
            k++;
        end
        if (k >= 60) chk("drain_timeout", k, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        for (int i = 0; i < N; i++) new_req(i);
        bus.out_ready = 1'b1;
        bus.cfg_slope = '0;
`ifdef ACT_RR_PERF_EN
        perf_clr = 1'b0;
`endif
        drive();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_out_func", bus.out_func, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        mask = 4'hf;
        req_pct = 100;
        rdy_pct = 100;
        repeat (16) cycle();

        drain();
        slope_rand = 1'b0;
        slope_drv = 16'sd2;
        dir_x = {-3, 5, 3, 2, -3, 7, -7, 0, -100, -2, 1, -1, 32767};
        dir_f = {1, 1, 2, 2, 2, 3, 3, 3, 0, 2, 2, 3, 1};
        drain();
        slope_rand = 1'b1;

        for (int i = 0; i < N; i++) new_req(i);
        mask = 4'h0;
        rdy_pct = 0;
        a0 = dut_acc;
        repeat (5) cycle();
        chk("bp_accepts", dut_acc - a0, 2);
        drain();

        new_req(2);
        cycle();
        new_req(2);
        cycle();
        new_req(0);
        new_req(2);
        cycle();
        drain();

        mask = 4'hf;
        req_pct = 60;
        rdy_pct = 70;
        clr_en = 1'b1;
        repeat (400) cycle();
        clr_en = 1'b0;

        for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
        req_pct = 100;
        rdy_pct = 0;
        repeat (4) cycle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_req_ready", bus.req_ready, 0);
`ifdef ACT_RR_PERF_EN
        chk("midrst_perf_acc", perf_accept_cnt, 0);
        chk("midrst_perf_stall", perf_stall_cnt, 0);
`endif
        q.delete();
        ptr_m = 0;
        acc_m = 0;
        stall_m = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_pct = 100;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
